bn_requant: RTL and testbench
=============================

# bn_requant

Per-channel batch-norm / requantization stage sitting directly upstream of the ReLU6 activation in the first block. Consumes a channel-interleaved stream of signed convolution accumulators and applies a per-channel Q8.8 scale and bias. Rounds and saturates the result to the 16-bit signed Q8.8 format the activation consumes. Three-stage pipeline with valid/ready handshake on both sides, and a coefficient write port.

## Interface
- `dataWidth`, 16 — output width; Q8.8 signed.
- `ACC_WIDTH`, 32 — input accumulator width; signed, 16 fractional bits.
- `NUM_CH`, 16 — number of channels; coefficient table depth, ≥2.
- `clk` in 1 — single clock; all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — input element valid.
- `in_ready` out 1 — stage can accept an element.
- `in_data` in `ACC_WIDTH` — signed accumulator, Q(ACC_WIDTH-16).16.
- `in_last` in 1 — last element of a tile; resyncs the channel counter.
- `out_valid` out 1 — output element valid.
- `out_ready` in 1 — downstream accepts.
- `out_data` out `dataWidth` — signed Q8.8 result.
- `out_last` out 1 — `in_last` delayed with its element.
- `coef_we` in 1 — coefficient write strobe.
- `coef_addr` in `$clog2(NUM_CH)` — channel to write.
- `coef_scale` in 16 — signed Q8.8 scale.
- `coef_bias` in 16 — signed Q8.8 bias.

## Operation
- **Transfer rule.** An element transfers on `in_valid && in_ready`. Output transfers on `out_valid && out_ready`.
- **Channel counter `ch`.**
  - Resets to 0.
  - On each accepted element, the element uses coefficients[`ch`].
  - `ch` then advances, wrapping `NUM_CH-1` → 0.
  - If the accepted element has `in_last=1`, `ch` returns to 0 regardless of its value.
- **Coefficient table.**
  - Reset values: scale=0x0100 (1.0), bias=0x0000 for every channel.
  - A write updates the entry at the clock edge.
  - An element accepted in the same cycle as a write to its channel uses the old value.
  - Writes with `coef_addr ≥ NUM_CH` are ignored.
- **S1.** `prod = in_data * scale`, signed, `ACC_WIDTH+16` bits, 24 fractional bits. `bias` and `last` are registered alongside.
- **S2.**
  - Round half-up: `r = (prod + 2^15) >>> 16`, arithmetic shift, giving 8 fractional bits.
  - `sum = r + sign_ext(bias)`, computed at `ACC_WIDTH+1` bits. No intermediate overflow is permitted.
- **S3.** Saturate `sum` to [0x8000, 0x7FFF] (−128.0 … +127.996) and drive `out_data`.
- **Stall.**
  - Pipeline-wide enable `en = !out_valid || out_ready`.
  - `in_ready = en`.
  - When `en=0`, every stage register, including valid bits, holds. `out_data` and `out_last` stay stable while `out_valid && !out_ready`.
- **Reset.** Clears all stage valid bits, `out_valid`, `out_data`, `out_last` and `ch`, and restores the coefficient table. In-flight elements are discarded. `in_ready` is 1 in the cycle after reset deasserts.

## Timing
- Latency is exactly 3 cycles from an input transfer to `out_valid` with the same element, when unstalled.
- Throughput is 1 element/cycle with `out_ready` held high.
- Reset values: `out_valid`=0, `out_data`=0x0000, `out_last`=0. `in_ready` is high during and after reset.
- Bubbles (`in_valid=0`) propagate as invalid slots. `ch` does not advance on bubbles.
- `in_ready` depends combinationally on `out_ready`. This is the only input-to-output combinational path.

## Configuration
- **`BN_FUSED_RELU6_EN` defined:** S3 clamps to [0x0000, 0x0600] instead of [0x8000, 0x7FFF], i.e. ReLU6 is fused and the downstream activation can be bypassed. Latency is unchanged.
- **Undefined:** signed Q8.8 saturation only, as described in Operation.

## Test plan
- **Basic arithmetic:** ch0 scale=0x0180, bias=0x0080; `in_data`=0x0002_0000 -> `out_data`=0x0380 exactly 3 cycles after acceptance.
- **Saturation:** scale=0x0100, bias=0. `in_data`=0x0100_0000 -> 0x7FFF; `in_data`=0xFF00_0000 -> 0x8000. With `BN_FUSED_RELU6_EN`, these give 0x0600 and 0x0000.
- **Rounding:** scale=0x0100, bias=0. `in_data`=0x0000_0080 -> 0x0001; `in_data`=0xFFFF_FF80 -> 0x0000; `in_data`=0x0000_007F -> 0x0000.
- **Channel wrap/resync:**
  - Setup: NUM_CH=4, scales 1.0/2.0/3.0/4.0, bias 0.
  - Stimulus: 10 elements of 1.0, with `in_last` on the 6th.
  - Required outputs: 0x0100, 0x0200, 0x0300, 0x0400, 0x0100, 0x0200, then 0x0100, 0x0200, 0x0300, 0x0400.
  - `out_last` is asserted only on the 6th output.
- **Backpressure:** continuous input with `out_ready` low for 5 cycles mid-stream -> `in_ready` low while stalled, `out_data` stable, no element lost or duplicated, order preserved.
- **Reset mid-stream / coef collision:**
  - Assert `rst` with 3 elements in flight -> `out_valid`=0 next cycle, nothing emitted afterward, `ch`=0.
  - Write ch0 scale=0x0200 in the same cycle as a ch0 element is accepted -> that element uses 0x0100; the next ch0 element uses 0x0200.

Source files
------------

// File: rtl/bn_requant.sv
// -----------------------------------------------------------------------------
// bn_requant -- per-channel batch-norm / requantization stage.
//
// Takes a channel-interleaved stream of signed accumulators (16 fractional
// bits). Each element is multiplied by a per-channel Q8.8 scale, rounded half-up
// to 8 fractional bits, offset by a per-channel Q8.8 bias and saturated to a
// signed 16-bit Q8.8 result. Three register stages, valid/ready on both sides.
//
// Parameters
//   dataWidth  output width (Q8.8 signed, 16)
//   ACC_WIDTH  input accumulator width (signed, 16 fractional bits)
//   NUM_CH     number of channels / coefficient table depth (>= 2)
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake
//   in_data, in_last      accumulator, end-of-tile marker (resyncs channel)
//   out_valid/out_ready   output handshake
//   out_data, out_last    Q8.8 result, in_last delayed with its element
//   coef_we, coef_addr    coefficient write strobe and channel
//   coef_scale, coef_bias Q8.8 scale and bias written on coef_we
//
// Build option
//   BN_FUSED_RELU6_EN  when defined the output clamp becomes [0.0, 6.0]
//                      (ReLU6 fused); otherwise full signed Q8.8 saturation.
// -----------------------------------------------------------------------------
module bn_requant #(
  parameter int dataWidth = 16,
  parameter int ACC_WIDTH = 32,
  parameter int NUM_CH    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ACC_WIDTH-1:0]        in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [dataWidth-1:0]        out_data,
  output logic                        out_last,
  input  logic                        coef_we,
  input  logic [$clog2(NUM_CH)-1:0]   coef_addr,
  input  logic [15:0]                 coef_scale,
  input  logic [15:0]                 coef_bias
);

  localparam int CW = $clog2(NUM_CH);
  localparam int PW = ACC_WIDTH + 16;  // product width, 24 fractional bits
  localparam int SW = ACC_WIDTH + 1;   // rounded sum width, 8 fractional bits
  localparam logic [CW-1:0] CH_MAX = CW'(NUM_CH - 1);

`ifdef BN_FUSED_RELU6_EN
  localparam logic signed [SW-1:0] SAT_HI = SW'(32'sd1536);  // 6.0 in Q8.8
  localparam logic signed [SW-1:0] SAT_LO = SW'(32'sd0);
`else
  localparam logic signed [SW-1:0] SAT_HI = SW'((64'sd1 <<< (dataWidth - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-(64'sd1 <<< (dataWidth - 1)));
`endif

  logic [CW-1:0]            ch_r;
  logic signed [15:0]       scale_r [NUM_CH];
  logic signed [15:0]       bias_r  [NUM_CH];

  logic                     en_s;
  logic                     accept_s;
  logic signed [PW-1:0]     prod_s;
  logic signed [PW-1:0]     rnd_full_s;
  logic signed [SW-1:0]     sum_s;
  logic [dataWidth-1:0]     sat_s;
  logic                     unused_rnd_s;

  logic                     v1_r;
  logic                     last1_r;
  logic signed [PW-1:0]     prod1_r;
  logic signed [15:0]       bias1_r;
  logic                     v2_r;
  logic                     last2_r;
  logic signed [SW-1:0]     sum2_r;
  logic                     out_valid_r;
  logic [dataWidth-1:0]     out_data_r;
  logic                     out_last_r;

  // The whole pipeline advances together; the only stall source is downstream.
  assign en_s      = !out_valid_r || out_ready;
  assign accept_s  = in_valid && en_s;
  assign in_ready  = en_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;

  // Coefficient table: reset to unity scale / zero bias, out-of-range writes dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scale_r[i] <= 16'sh0100;
        bias_r[i]  <= 16'sh0000;
      end
    end else if (coef_we && ({{(32-CW){1'b0}}, coef_addr} < 32'(NUM_CH))) begin
      scale_r[coef_addr] <= coef_scale;
      bias_r[coef_addr]  <= coef_bias;
    end
  end

  // Channel counter: advances per accepted element, in_last forces channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_r <= {CW{1'b0}};
    end else if (accept_s) begin
      if (in_last || (ch_r == CH_MAX)) begin
        ch_r <= {CW{1'b0}};
      end else begin
        ch_r <= ch_r + CW'(1'b1);
      end
    end
  end

  // Stage-1 multiply and stage-2 round/bias arithmetic. The table is read
  // before the write edge, so a same-cycle write to this channel is not seen.
  always_comb begin
    prod_s       = $signed({{16{in_data[ACC_WIDTH-1]}}, in_data})
                 * $signed({{ACC_WIDTH{scale_r[ch_r][15]}}, scale_r[ch_r]});
    rnd_full_s   = prod1_r + $signed({{(PW-16){1'b0}}, 16'h8000});
    // Bits [PW-1:16] are the half-up rounded value with 8 fractional bits.
    sum_s        = $signed({rnd_full_s[PW-1], rnd_full_s[PW-1:16]})
                 + $signed({{(SW-16){bias1_r[15]}}, bias1_r});
    unused_rnd_s = ^rnd_full_s[15:0];
  end

  // Stage-3 clamp of the registered sum to the output range.
  always_comb begin
    sat_s = sum2_r[dataWidth-1:0];
    if (sum2_r > SAT_HI) begin
      sat_s = SAT_HI[dataWidth-1:0];
    end else if (sum2_r < SAT_LO) begin
      sat_s = SAT_LO[dataWidth-1:0];
    end else begin
      sat_s = sum2_r[dataWidth-1:0];
    end
  end

  // Pipeline registers; everything (valid bits included) holds when stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r        <= 1'b0;
      last1_r     <= 1'b0;
      prod1_r     <= {PW{1'b0}};
      bias1_r     <= 16'sh0000;
      v2_r        <= 1'b0;
      last2_r     <= 1'b0;
      sum2_r      <= {SW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {dataWidth{1'b0}};
      out_last_r  <= 1'b0;
    end else if (en_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        prod1_r <= prod_s;
        bias1_r <= bias_r[ch_r];
        last1_r <= in_last;
      end
      v2_r <= v1_r;
      if (v1_r) begin
        sum2_r  <= sum_s;
        last2_r <= last1_r;
      end
      out_valid_r <= v2_r;
      out_last_r  <= v2_r && last2_r;
      if (v2_r) begin
        out_data_r <= sat_s;
      end
    end
  end

endmodule

// File: tb/tb_bn_requant.sv
// -----------------------------------------------------------------------------
// tb_bn_requant -- directed self-checking bench for bn_requant (NUM_CH = 4).
// A driver task pushes hand-computed {last, data} expectations when an element
// is accepted; an output monitor pops and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_bn_requant;

  localparam int DW = 16;
  localparam int AW = 32;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          coef_we;
  logic [1:0]    coef_addr;
  logic [15:0]   coef_scale;
  logic [15:0]   coef_bias;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_acc    = 0;
  int            n_out    = 0;
  logic [16:0]   exp_q [$];
  logic [16:0]   mon_e;
  logic [15:0]   wrap_exp [10];
  logic [15:0]   held;
  int            lat;

  always #5 clk = ~clk;

  bn_requant #(.dataWidth(DW), .ACC_WIDTH(AW), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_scale(coef_scale), .coef_bias(coef_bias)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] clampq(input int v);
`ifdef BN_FUSED_RELU6_EN
    if (v > 1536) return 16'h0600;
    if (v < 0) return 16'h0000;
`else
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return 16'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [1:0] a, input logic [15:0] s, input logic [15:0] b);
    coef_we = 1'b1; coef_addr = a; coef_scale = s; coef_bias = b;
    tick();
    coef_we = 1'b0;
  endtask

  // Offer one element until accepted (bounded); record its expectation.
  task automatic send(input logic [31:0] d, input logic l, input logic [15:0] e);
    int  tries = 0;
    bit  done  = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({l, e});
        n_acc++;
        done = 1'b1;
      end else if (tries > 50) begin
        check_val("send_timeout", {31'd0, in_ready}, 32'd1);
        done = 1'b1;
      end
      tries++;
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    check_val("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: every output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", {15'd0, out_last, out_data}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("out_data", {16'd0, out_data}, {16'd0, mon_e[15:0]});
        check_val("out_last", {31'd0, out_last}, {31'd0, mon_e[16]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wrap_exp = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0100,
                 16'h0200, 16'h0100, 16'h0200, 16'h0300, 16'h0400};
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
    out_ready = 1'b1; coef_we = 1'b0; coef_addr = 2'd0;
    coef_scale = 16'd0; coef_bias = 16'd0;
    repeat (3) tick();

    // Reset state
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_out_data", {16'd0, out_data}, 32'd0);
    check_val("rst_out_last", {31'd0, out_last}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    tick();
    check_val("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic arithmetic: 2.0 * 1.5 + 0.5 = 3.5, latency 3
    write_coef(2'd0, 16'h0180, 16'h0080);
    send(32'h0002_0000, 1'b1, 16'h0380);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_val("latency", 32'(lat), 32'd3);
    drain();

    // Saturation and rounding, all on channel 0 (in_last keeps ch at 0)
    write_coef(2'd0, 16'h0100, 16'h0000);
`ifdef BN_FUSED_RELU6_EN
    send(32'h0100_0000, 1'b1, 16'h0600);
    send(32'hFF00_0000, 1'b1, 16'h0000);
`else
    send(32'h0100_0000, 1'b1, 16'h7FFF);
    send(32'hFF00_0000, 1'b1, 16'h8000);
`endif
    send(32'h0000_0080, 1'b1, 16'h0001);
    send(32'hFFFF_FF80, 1'b1, 16'h0000);
    send(32'h0000_007F, 1'b1, 16'h0000);
    drain();

    // Channel wrap and resync on in_last (6th element)
    for (int c = 0; c < 4; c++) write_coef(2'(c), 16'(c + 1) << 8, 16'h0000);
    for (int i = 0; i < 10; i++) send(32'h0001_0000, (i == 5), wrap_exp[i]);
    drain();

    // Backpressure: out_ready low for 5 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(32'(i + 1) << 16, (i == 11), clampq((i + 1) * ((i % 4) + 1) * 256));
      end
      begin
        repeat (5) tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k == 0) held = out_data;
          check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
          check_val("stall_out_valid", {31'd0, out_valid}, 32'd1);
          if (k > 0) check_val("stall_out_data_stable", {16'd0, out_data}, {16'd0, held});
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check_val("bp_count", 32'(n_out), 32'(n_acc));

    // Coefficient write colliding with a ch0 element: old value used once
    coef_we = 1'b1; coef_addr = 2'd0; coef_scale = 16'h0200; coef_bias = 16'h0000;
    send(32'h0001_0000, 1'b0, 16'h0100);
    coef_we = 1'b0;
    send(32'h0001_0000, 1'b0, 16'h0200);
    send(32'h0001_0000, 1'b0, 16'h0300);
    send(32'h0001_0000, 1'b0, 16'h0400);
    send(32'h0001_0000, 1'b1, 16'h0200);
    drain();

    // Reset with three elements in flight
    send(32'h0001_0000, 1'b0, 16'h0200);
    send(32'h0001_0000, 1'b0, 16'h0200);
    send(32'h0001_0000, 1'b0, 16'h0300);
    rst = 1'b1;
    tick();
    check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    n_acc -= exp_q.size();
    exp_q.delete();
    rst = 1'b0;
    repeat (6) tick();
    check_val("midrst_quiet", {31'd0, out_valid}, 32'd0);
    // ch0 scale must be back to 1.0 and ch back to 0 (ch3 would give 4.0)
    write_coef(2'd1, 16'h0200, 16'h0000);
    write_coef(2'd2, 16'h0300, 16'h0000);
    write_coef(2'd3, 16'h0400, 16'h0000);
    send(32'h0001_0000, 1'b0, 16'h0100);
    send(32'h0001_0000, 1'b1, 16'h0200);
    drain();
    check_val("total_count", 32'(n_out), 32'(n_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
